// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Holds RV32I load/store funct3 codes, FSM state encoding and wait-counter width.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_if.sv
// MEM-stage <-> data-memory handshake bundle.
// Build macro DMEM_STALL_CNT_EN adds the stall_cnt_o observation signal.
interface dmem_if;
  import dmem_pkg::*;

  logic        req_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        done_o;
  logic        err_o;
`ifdef DMEM_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  modport slave (
    input  req_i, we_i, funct3_i, addr_i, wdata_i,
`ifdef DMEM_STALL_CNT_EN
    output stall_cnt_o,
`endif
    output rdata_o, stall_o, done_o, err_o
  );

  modport master (
    output req_i, we_i, funct3_i, addr_i, wdata_i,
`ifdef DMEM_STALL_CNT_EN
    input  stall_cnt_o,
`endif
    input  rdata_o, stall_o, done_o, err_o
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store enables/shifted data, load extract/extend,
// and the misaligned-or-illegal flag for a funct3/address pair.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_c,
  output logic [31:0] rdata_c,
  output logic        bad_c
);

  logic [4:0]  shamt;
  logic [31:0] rshift;

  always_comb begin
    shamt   = {addr_lo_i, 3'b000};
    rshift  = rword_i >> shamt;
    wdata_c = wdata_i << shamt;
    be_c    = 4'b0000;
    rdata_c = 32'd0;
    bad_c   = 1'b0;
    unique case (funct3_i)
      F3_B: begin
        be_c    = 4'b0001 << addr_lo_i;
        rdata_c = {{24{rshift[7]}}, rshift[7:0]};
      end
      F3_H: begin
        be_c    = 4'b0011 << addr_lo_i;
        bad_c   = addr_lo_i[0];
        rdata_c = {{16{rshift[15]}}, rshift[15:0]};
      end
      F3_W: begin
        be_c    = 4'b1111;
        bad_c   = |addr_lo_i;
        rdata_c = rword_i;
      end
      // Unsigned variants exist only for loads
      F3_BU: begin
        bad_c   = we_i;
        rdata_c = {24'd0, rshift[7:0]};
      end
      F3_HU: begin
        bad_c   = we_i | addr_lo_i[0];
        rdata_c = {16'd0, rshift[15:0]};
      end
      default: bad_c = 1'b1;
    endcase
    if (bad_c) be_c = 4'b0000;
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder for the MEM stage: wait-stated load/store on an internal word array.
// Build macro DMEM_STALL_CNT_EN adds a saturating stall-cycle counter on stall_cnt_o.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  dmem_if.slave bus
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam int unsigned BW        = AW + 2;
  // IDLE is the first stall cycle, so BUSY lasts WAIT_CYCLES cycles
  localparam int unsigned WAIT_LOAD = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [BW-1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [31:0]       mem [DEPTH_WORDS];
  logic              acc_we;
  logic [2:0]        acc_f3;
  logic [BW-1:0]     acc_addr;
  logic [31:0]       acc_wdata;
  logic [AW-1:0]     idx;
  logic [3:0]        be;
  logic [31:0]       wdata_sh, ld_data;
  logic              bad;
  logic              do_access;
  logic              mem_we;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^bus.addr_i[31:BW];

  // In IDLE the live request is decoded; afterwards the latched copy drives the access
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = bus.we_i;
      acc_f3    = bus.funct3_i;
      acc_addr  = bus.addr_i[BW-1:0];
      acc_wdata = bus.wdata_i;
    end else begin
      acc_we    = we_q;
      acc_f3    = f3_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign idx = acc_addr[BW-1:2];

  dmem_lane_align u_lane_align (
    .we_i      (acc_we),
    .funct3_i  (acc_f3),
    .addr_lo_i (acc_addr[1:0]),
    .wdata_i   (acc_wdata),
    .rword_i   (mem[idx]),
    .be_c      (be),
    .wdata_c   (wdata_sh),
    .rdata_c   (ld_data),
    .bad_c     (bad)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    do_access = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          we_d    = bus.we_i;
          f3_d    = bus.funct3_i;
          addr_d  = bus.addr_i[BW-1:0];
          wdata_d = bus.wdata_i;
          if (bad) begin
            state_d = RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else if (WAIT_CYCLES == 0) begin
            state_d   = RESP;
            done_d    = 1'b1;
            do_access = 1'b1;
          end else begin
            cnt_d   = CNT_W'(WAIT_LOAD);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d   = RESP;
          done_d    = 1'b1;
          do_access = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (do_access && !acc_we) rdata_d = ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; reset low blocks any write that would land on a reset edge
  assign mem_we = do_access && acc_we && rst_n;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign bus.stall_o = bus.req_i && (state_q != RESP);
  assign bus.rdata_o = rdata_q;
  assign bus.done_o  = done_q;
  assign bus.err_o   = err_q;

`ifdef DMEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= 32'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt_o = stall_cnt_q;
`endif

endmodule
